// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU result stage and its testbench.
//   ALU_WIDTH    : datapath width that the result entry is built for
//   OP_*         : 5-bit ALU opcodes understood by the result selector
//   alu_entry_t  : one buffered result {data, is_not_equal, is_less_than,
//                  overflow, illegal_op}
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic                 is_not_equal;
        logic                 is_less_than;
        logic                 overflow;
        logic                 illegal_op;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_select.sv
// ---------------------------------------------------------------------------
// alu_result_select
// Combinational opcode mux and flag generation for the ALU result stage.
//   opcode                  : ALU opcode (see alu_pkg OP_*)
//   and/or/add/sub/sll/sra_result : parallel sub-unit results
//   add_overflow/sub_overflow     : signed overflow of adder/subtractor
//   entry                   : selected result plus flags, ready to buffer
// WIDTH must equal alu_pkg::ALU_WIDTH, since the entry struct is sized by it.
// ---------------------------------------------------------------------------
module alu_result_select
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] add_result,
    input  logic [WIDTH-1:0] sub_result,
    input  logic [WIDTH-1:0] sll_result,
    input  logic [WIDTH-1:0] sra_result,
    input  logic             add_overflow,
    input  logic             sub_overflow,
    output alu_entry_t       entry
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        entry = '0;
        case (opcode)
            OP_ADD: begin
                entry.data     = add_result;
                entry.overflow = add_overflow;
            end
            OP_SUB: begin
                entry.data     = sub_result;
                entry.overflow = sub_overflow;
            end
            OP_AND:  entry.data = and_result;
            OP_OR:   entry.data = or_result;
            OP_SLL:  entry.data = sll_result;
            OP_SRA:  entry.data = sra_result;
            default: entry.illegal_op = 1'b1;
        endcase

        // Compare flags come from the subtractor regardless of which result
        // is selected; an illegal opcode reports nothing but illegal_op.
        if (!entry.illegal_op) begin
            entry.is_not_equal = |sub_result;
            // Sign of the difference, corrected when the subtraction overflowed.
            entry.is_less_than = sub_result[WIDTH-1] ^ sub_overflow;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Output stage of the ALU: selects the sub-unit result by opcode, computes
// compare/overflow flags and holds results in a 2-entry skid buffer toward
// writeback.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready depends on count only)
//   opcode, *_result, *_overflow : operation and parallel sub-unit results
//   flush               : synchronous discard of all buffered entries
//   out_valid/out_ready : downstream handshake for the head entry
//   out_data, out_is_not_equal, out_is_less_than, out_overflow,
//   out_illegal_op      : head entry fields, 0 whenever out_valid is 0
// ---------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] add_result,
    input  logic [WIDTH-1:0] sub_result,
    input  logic [WIDTH-1:0] sll_result,
    input  logic [WIDTH-1:0] sra_result,
    input  logic             add_overflow,
    input  logic             sub_overflow,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_not_equal,
    output logic             out_is_less_than,
    output logic             out_overflow,
    output logic             out_illegal_op
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    alu_entry_t new_entry;
    alu_entry_t head_q;
    alu_entry_t tail_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    alu_result_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .opcode       (opcode),
        .and_result   (and_result),
        .or_result    (or_result),
        .add_result   (add_result),
        .sub_result   (sub_result),
        .sll_result   (sll_result),
        .sra_result   (sra_result),
        .add_overflow (add_overflow),
        .sub_overflow (sub_overflow),
        .entry        (new_entry)
    );

    // in_ready looks only at count so the writeback stall (out_ready) never
    // reaches back into the ALU combinational path.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // head_q is always the oldest entry; tail_q is only meaningful at count 2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the entry registers are reset, not just count, because the
            // outputs are read straight from head_q and must show 0 when empty.
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            // Flush wins over any push or pop in the same cycle.
            count_q <= 2'd0;
            head_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the count/head
            // updates below all see the values from before this edge.
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= new_entry;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= new_entry;
                            count_q <= 2'd2;
                        end
                        2'b01: begin
                            head_q  <= '0;
                            count_q <= 2'd0;
                        end
                        2'b11:   head_q <= new_entry;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Full: no push possible, a pop promotes the second entry.
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: begin
                    count_q <= 2'd0;
                    head_q  <= '0;
                end
            endcase
        end
    end

    assign out_data         = head_q.data;
    assign out_is_not_equal = head_q.is_not_equal;
    assign out_is_less_than = head_q.is_less_than;
    assign out_overflow     = head_q.overflow;
    assign out_illegal_op   = head_q.illegal_op;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Self-checking bench for alu_result_stage: a queue-based reference model is
// compared against the DUT on every falling edge, and directed vectors carry
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] and_result;
    logic [WIDTH-1:0] or_result;
    logic [WIDTH-1:0] add_result;
    logic [WIDTH-1:0] sub_result;
    logic [WIDTH-1:0] sll_result;
    logic [WIDTH-1:0] sra_result;
    logic             add_overflow;
    logic             sub_overflow;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_is_not_equal;
    logic             out_is_less_than;
    logic             out_overflow;
    logic             out_illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .DEPTH (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .opcode           (opcode),
        .and_result       (and_result),
        .or_result        (or_result),
        .add_result       (add_result),
        .sub_result       (sub_result),
        .sll_result       (sll_result),
        .sra_result       (sra_result),
        .add_overflow     (add_overflow),
        .sub_overflow     (sub_overflow),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_is_not_equal (out_is_not_equal),
        .out_is_less_than (out_is_less_than),
        .out_overflow     (out_overflow),
        .out_illegal_op   (out_illegal_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    alu_entry_t model_q[$];
    alu_entry_t m_entry;
    bit         m_push;
    bit         m_pop;

    // Expected entry straight from the opcode table and flag definitions.
    function automatic alu_entry_t expected_entry();
        alu_entry_t e;
        bit legal;
        e = '0;
        legal = 1'b1;
        if (opcode == OP_ADD) begin
            e.data = add_result;
            e.overflow = add_overflow;
        end else if (opcode == OP_SUB) begin
            e.data = sub_result;
            e.overflow = sub_overflow;
        end else if (opcode == OP_AND) e.data = and_result;
        else if (opcode == OP_OR)  e.data = or_result;
        else if (opcode == OP_SLL) e.data = sll_result;
        else if (opcode == OP_SRA) e.data = sra_result;
        else legal = 1'b0;
        if (legal) begin
            e.is_not_equal = (sub_result != 0);
            e.is_less_than = (($signed(sub_result) < 0) != sub_overflow);
        end else begin
            e.illegal_op = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clock) begin
        if (reset_n) begin
            m_push  = in_valid && (model_q.size() < 2);
            m_pop   = (model_q.size() > 0) && out_ready;
            m_entry = expected_entry();
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) model_q.push_back(m_entry);
            end
        end
    end

    always @(negedge reset_n) model_q.delete();

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        alu_entry_t h;
        h = (model_q.size() > 0) ? model_q[0] : alu_entry_t'('0);
        check("cyc_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        check("cyc_in_ready", 64'(in_ready), 64'(model_q.size() != 2));
        check("cyc_head", 64'({out_data, out_is_not_equal, out_is_less_than,
                               out_overflow, out_illegal_op}), 64'(h));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] head_bits();
        return 64'({out_data, out_is_not_equal, out_is_less_than, out_overflow, out_illegal_op});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; opcode = OP_ADD; flush = 0; out_ready = 1;
        and_result = 0; or_result = 0; add_result = 0; sub_result = 0;
        sll_result = 0; sra_result = 0; add_overflow = 0; sub_overflow = 0;

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_head", head_bits(), 64'd0);

        // A valid op while reset is held must not be captured
        in_valid = 1; add_result = 32'h1234_5678;
        tick();
        check("rst_no_push", 64'(out_valid), 64'd0);
        in_valid = 0;
        tick();
        reset_n = 1;
        tick();

        // OR with nonzero positive sub_result
        in_valid = 1; opcode = OP_OR; or_result = 32'hF0F0_00FF; sub_result = 32'h5;
        tick();
        check("or_valid", 64'(out_valid), 64'd1);
        check("or_data", 64'(out_data), 64'hF0F0_00FF);
        check("or_flags", 64'({out_is_not_equal, out_is_less_than, out_overflow, out_illegal_op}), 64'b1000);

        // SUB negative difference, then zero difference
        opcode = OP_SUB; sub_result = 32'hFFFF_FFFE; sub_overflow = 0;
        tick();
        check("sub_neg_data", 64'(out_data), 64'hFFFF_FFFE);
        check("sub_neg_flags", 64'({out_is_not_equal, out_is_less_than}), 64'b11);
        sub_result = 32'h0;
        tick();
        check("sub_zero", head_bits(), 64'd0);

        // ADD with overflow, then illegal opcode
        opcode = OP_ADD; add_result = 32'h8000_0000; add_overflow = 1; sub_result = 32'h7;
        tick();
        check("add_ovf_data", 64'(out_data), 64'h8000_0000);
        check("add_ovf_flag", 64'(out_overflow), 64'd1);
        opcode = 5'b01111; sub_result = 32'h10;
        tick();
        check("illegal_head", head_bits(), 64'd1);
        add_overflow = 0;

        // Drain: the pop that empties the buffer clears the outputs
        in_valid = 0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_data", 64'(out_data), 64'd0);

        // Backpressure: A, B fill the buffer, C is held off
        out_ready = 0; in_valid = 1; opcode = OP_ADD; sub_result = 32'h1;
        add_result = 32'hA;
        tick();
        add_result = 32'hB;
        tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        add_result = 32'hC;
        tick();
        check("full_still", 64'(in_ready), 64'd0);
        check("full_head_a", 64'(out_data), 64'hA);
        out_ready = 1;
        tick();
        check("promote_b", 64'(out_data), 64'hB);
        check("promote_ready", 64'(in_ready), 64'd1);
        tick();
        check("head_c", 64'(out_data), 64'hC);
        in_valid = 0;
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Streaming 8 ops at full rate
        in_valid = 1; opcode = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            add_result = 32'(100 + i);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(100 + i));
        end
        in_valid = 0;
        tick();
        check("stream_end", 64'(out_valid), 64'd0);

        // Flush with a full buffer and a pending push
        out_ready = 0; in_valid = 1; opcode = OP_SLL; sll_result = 32'h11;
        tick();
        sll_result = 32'h22;
        tick();
        check("pre_flush_full", 64'(in_ready), 64'd0);
        flush = 1; sll_result = 32'h33;
        tick();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        check("flush_nothing", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 0; in_valid = 1; opcode = OP_SRA; sra_result = 32'hFFFF_F000;
        tick();
        tick();
        in_valid = 0;
        #2 reset_n = 0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_head", head_bits(), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        tick();
        reset_n = 1;
        tick();

        // Recovery after reset
        out_ready = 1; in_valid = 1; opcode = OP_AND; and_result = 32'h0F0F_0F0F; sub_result = 32'h8000_0000;
        tick();
        check("recover_data", 64'(out_data), 64'h0F0F_0F0F);
        check("recover_lt", 64'(out_is_less_than), 64'd1);
        in_valid = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
